// File: rtl/hydra_router.sv
// hydra_router: routes FIFO packets to per-port TX UARTs and round-robin merges
// per-port RX UART packets into a single stream with a bounded consumer wait.
module hydra_router #(
  parameter int PKT_W   = 63,
  parameter int NPORT   = 4,
  parameter int DIR_BIT = 62,
  parameter int TIMEOUT = 47
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [PKT_W-1:0]       fifo_data,
  input  logic                   ld_tx_data,
  input  logic [NPORT-1:0]       enable_piso_upstream,
  input  logic [NPORT-1:0]       enable_piso_downstream,
  input  logic [NPORT-1:0]       enable_posi,
  input  logic [NPORT-1:0]       tx_busy,
  input  logic [NPORT-1:0]       rx_empty_uart,
  input  logic [NPORT*PKT_W-1:0] rx_data_in,
  input  logic                   comms_busy,
  output logic [NPORT*PKT_W-1:0] tx_data,
  output logic [NPORT-1:0]       ld_tx_data_uart,
  output logic [NPORT-1:0]       uld_rx_data_uart,
  output logic [NPORT-1:0]       rx_enable,
  output logic [NPORT-1:0]       tx_enable,
  output logic                   tx_busy_any,
  output logic [PKT_W-1:0]       rx_data,
  output logic                   rx_data_flag,
  output logic                   rx_timeout,
  output logic                   tx_drop
);
  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT, NEXT} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [PW-1:0] rr_q, rr_d, grant, idx;
  logic [NPORT-1:0] pend_q, pend_d, uld_q, uld_d, clr, target, send, ld_q;
  logic [PKT_W-1:0] hold_q [NPORT];
  logic [PKT_W-1:0] rx_data_q, tx_hold_q;
  logic [NPORT*PKT_W-1:0] tx_data_q;
  logic flag_q, to_q, to_d, drop_q, drop_d, tx_vld_q, dir_q, live_q;
  assign rx_enable        = enable_posi;
  assign tx_enable        = enable_piso_upstream | enable_piso_downstream;
  assign tx_busy_any      = |tx_busy;
  assign tx_data          = tx_data_q;
  assign ld_tx_data_uart  = ld_q;
  assign uld_rx_data_uart = uld_q;
  assign rx_data          = rx_data_q;
  assign rx_data_flag     = flag_q;
  assign rx_timeout       = to_q;
  assign tx_drop          = drop_q;
  // Descending scan so the nearest pending port at or after rr_q wins.
  always_comb begin
    grant = rr_q;
    idx   = rr_q;
    for (int k = NPORT - 1; k >= 0; k--) begin
      idx = PW'((int'(rr_q) + k) % NPORT);
      if (pend_q[idx]) grant = idx;
    end
  end
  // live_q keeps the first cycle after reset release free of unload pulses.
  assign uld_d  = ~rx_empty_uart & ~pend_q & ~uld_q & {NPORT{live_q}};
  assign clr    = (state_q == LOAD) ? (NPORT'(1) << grant) : '0;
  assign pend_d = (pend_q & ~clr) | (uld_d & enable_posi);
  assign rr_d   = (state_q != LOAD) ? rr_q : (grant == PW'(NPORT - 1)) ? '0 : grant + PW'(1);
  assign target = dir_q ? enable_piso_downstream : enable_piso_upstream;
  assign send   = tx_vld_q ? (target & ~tx_busy) : '0;
  assign drop_d = tx_vld_q & ((target == '0) | (|(target & tx_busy)));
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: state_d = (|pend_q) ? LOAD : IDLE;
      LOAD: state_d = WAIT;
      WAIT: begin
        timer_d = timer_q + TW'(1);
        if (!comms_busy) state_d = NEXT;
        else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d = NEXT;
          to_d    = 1'b1;
        end
      end
      NEXT: begin
        timer_d = '0;
        state_d = (|pend_q) ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_q   <= '0;
      rr_q      <= '0;
      pend_q    <= '0;
      uld_q     <= '0;
      live_q    <= 1'b0;
      flag_q    <= 1'b0;
      to_q      <= 1'b0;
      rx_data_q <= '0;
      tx_hold_q <= '0;
      dir_q     <= 1'b0;
      tx_vld_q  <= 1'b0;
      ld_q      <= '0;
      drop_q    <= 1'b0;
      tx_data_q <= '0;
      for (int i = 0; i < NPORT; i++) hold_q[i] <= '0;
    end else begin
      timer_q  <= timer_d;
      rr_q     <= rr_d;
      pend_q   <= pend_d;
      uld_q    <= uld_d;
      live_q   <= 1'b1;
      flag_q   <= (state_q == LOAD);
      to_q     <= to_d;
      tx_vld_q <= ld_tx_data;
      ld_q     <= send;
      drop_q   <= drop_d;
      if (state_q == LOAD) rx_data_q <= hold_q[grant];
      if (ld_tx_data) begin
        tx_hold_q <= fifo_data;
        dir_q     <= fifo_data[DIR_BIT];
      end
      for (int i = 0; i < NPORT; i++) begin
        if (uld_d[i] && enable_posi[i]) hold_q[i] <= rx_data_in[i*PKT_W +: PKT_W];
        if (send[i]) tx_data_q[i*PKT_W +: PKT_W] <= tx_hold_q;
      end
    end
  end
endmodule

// File: tb/tb_hydra_router.sv
// tb_hydra_router: randomized and directed bench for hydra_router against a
// cycle-level behavioural model of the router's rules.
module tb_hydra_router;
  localparam int N = 4, W = 63, TO = 47, DB = 62;
  localparam int S_IDLE = 0, S_LOAD = 1, S_WAIT = 2, S_NEXT = 3;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic [W-1:0] fifo_data;
  logic ld_tx_data, comms_busy;
  logic [N-1:0] en_up, en_dn, en_posi, tx_busy, rx_empty;
  logic [N*W-1:0] rx_data_in, tx_data;
  logic [N-1:0] ld_uart, uld, rx_enable, tx_enable;
  logic tx_busy_any, rx_data_flag, rx_timeout, tx_drop;
  logic [W-1:0] rx_data;
  int n_chk = 0, n_err = 0;
  bit m_pend[N], m_uld[N], m_ld[N];
  logic [W-1:0] m_hold[N], m_txd[N];
  bit m_live, m_flag, m_to, m_txv, m_dir, m_drop;
  int m_st, m_tmr, m_rr;
  logic [W-1:0] m_rxd, m_txh;

  hydra_router dut (
    .clk(clk), .reset_n(reset_n), .fifo_data(fifo_data), .ld_tx_data(ld_tx_data),
    .enable_piso_upstream(en_up), .enable_piso_downstream(en_dn), .enable_posi(en_posi),
    .tx_busy(tx_busy), .rx_empty_uart(rx_empty), .rx_data_in(rx_data_in),
    .comms_busy(comms_busy), .tx_data(tx_data), .ld_tx_data_uart(ld_uart),
    .uld_rx_data_uart(uld), .rx_enable(rx_enable), .tx_enable(tx_enable),
    .tx_busy_any(tx_busy_any), .rx_data(rx_data), .rx_data_flag(rx_data_flag),
    .rx_timeout(rx_timeout), .tx_drop(tx_drop)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: got no finish expected finish within 5ms");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [N*W-1:0] got, input logic [N*W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0; m_uld[i] = 0; m_ld[i] = 0; m_hold[i] = '0; m_txd[i] = '0;
    end
    m_live = 0; m_flag = 0; m_to = 0; m_txv = 0; m_dir = 0; m_drop = 0;
    m_st = S_IDLE; m_tmr = 0; m_rr = 0; m_rxd = '0; m_txh = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    int g;
    bit nu[N];
    logic [N-1:0] tgt;
    g = -1;
    for (int k = 0; k < N; k++) if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
    for (int i = 0; i < N; i++) nu[i] = m_live && !rx_empty[i] && !m_pend[i] && !m_uld[i];
    m_flag = (m_st == S_LOAD);
    m_to = 0;
    if (m_st == S_LOAD && g >= 0) begin
      m_rxd = m_hold[g];
      m_pend[g] = 0;
      m_rr = (g + 1) % N;
    end
    case (m_st)
      S_IDLE: if (g >= 0) m_st = S_LOAD;
      S_LOAD: m_st = S_WAIT;
      S_WAIT: begin
        if (!comms_busy) m_st = S_NEXT;
        else if (m_tmr == TO - 1) begin m_st = S_NEXT; m_to = 1; end
        m_tmr++;
      end
      default: begin m_tmr = 0; m_st = (g >= 0) ? S_LOAD : S_IDLE; end
    endcase
    for (int i = 0; i < N; i++) begin
      if (nu[i] && en_posi[i]) begin m_pend[i] = 1; m_hold[i] = rx_data_in[i*W +: W]; end
      m_uld[i] = nu[i];
    end
    m_live = 1;
    tgt = m_dir ? en_dn : en_up;
    m_drop = m_txv && (tgt == '0 || (tgt & tx_busy) != '0);
    for (int i = 0; i < N; i++) begin
      m_ld[i] = m_txv && tgt[i] && !tx_busy[i];
      if (m_ld[i]) m_txd[i] = m_txh;
    end
    m_txv = ld_tx_data;
    if (ld_tx_data) begin m_txh = fifo_data; m_dir = fifo_data[DB]; end
  endtask

  task automatic check_all();
    logic [N-1:0] eu, el;
    logic [N*W-1:0] et;
    for (int i = 0; i < N; i++) begin eu[i] = m_uld[i]; el[i] = m_ld[i]; et[i*W +: W] = m_txd[i]; end
    chk("uld", uld, eu);
    chk("ld_uart", ld_uart, el);
    chk("tx_data", tx_data, et);
    chk("rx_data", rx_data, m_rxd);
    chk("rx_flag", rx_data_flag, m_flag);
    chk("rx_timeout", rx_timeout, m_to);
    chk("tx_drop", tx_drop, m_drop);
    chk("rx_enable", rx_enable, en_posi);
    chk("tx_enable", tx_enable, en_up | en_dn);
    chk("tx_busy_any", tx_busy_any, |tx_busy);
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    fifo_data = '0; ld_tx_data = 0; comms_busy = 0; en_up = '0; en_dn = '0;
    en_posi = '1; tx_busy = '0; rx_empty = '1; rx_data_in = '0;
  endtask

  task automatic do_reset();
    #2 reset_n = 0;
    #1;
    model_reset();
    check_all();
    chk("rst_regs", {uld, ld_uart, rx_data_flag, rx_timeout, tx_drop, rx_data, tx_data}, '0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
  endtask

  initial begin
    logic [W-1:0] fd, fd2;
    logic [W-1:0] q[$];
    int n, seen, busy_hold;
    idle_inputs();
    do_reset();
    // First cycle after release must not unload; the next one does.
    rx_empty = 4'b1110; rx_data_in[0 +: W] = 'h55;
    cyc(); chk("rel_no_pulse", uld, 4'b0000);
    cyc(); chk("rel_uld", uld, 4'b0001);
    rx_empty = '1;
    repeat (6) cyc();
    // rr now 1: ports 0 and 3 together, port 3 first.
    rx_empty = 4'b0110; rx_data_in[0 +: W] = 'hA0; rx_data_in[3*W +: W] = 'hA3;
    cyc(); chk("p03_uld", uld, 4'b1001);
    rx_empty = '1;
    cyc(); cyc();
    chk("p03_first_flag", rx_data_flag, 1); chk("p03_first_data", rx_data, 'hA3);
    repeat (3) cyc();
    chk("p03_second_flag", rx_data_flag, 1); chk("p03_second_data", rx_data, 'hA0);
    repeat (4) cyc();
    // Single port 2 packet, two-cycle latency.
    rx_empty = 4'b1011; rx_data_in[2*W +: W] = 'h1234;
    cyc(); chk("p2_uld", uld, 4'b0100);
    rx_empty = '1;
    cyc(); chk("p2_no_flag_yet", rx_data_flag, 0);
    cyc(); chk("p2_flag", rx_data_flag, 1); chk("p2_data", rx_data, 'h1234);
    repeat (4) cyc();
    // Timeout with consumer stuck busy.
    comms_busy = 1; rx_empty = 4'b1101; rx_data_in[W +: W] = 'h77;
    cyc(); rx_empty = '1; cyc(); cyc();
    chk("to_flag", rx_data_flag, 1);
    n = 0; seen = 0;
    while (n < 100 && !seen) begin cyc(); n++; seen = rx_timeout; end
    chk("to_seen", seen, 1);
    chk("to_cycles", n, TO);
    cyc(); chk("to_single_pulse", rx_timeout, 0);
    comms_busy = 0;
    repeat (3) cyc();
    // Downstream packet, one busy target.
    fd = rnd(); fd[DB] = 1'b1;
    fifo_data = fd; en_dn = 4'b0011; en_up = 4'b1100; tx_busy = 4'b0010; ld_tx_data = 1;
    cyc(); ld_tx_data = 0;
    cyc(); chk("tx_ld", ld_uart, 4'b0001); chk("tx_drop_busy", tx_drop, 1);
    chk("tx_slice0", tx_data[0 +: W], fd);
    chk("tx_slice1_kept", tx_data[W +: W], '0);
    // Back-to-back upstream strobes.
    fd = rnd(); fd[DB] = 1'b0; fd2 = rnd(); fd2[DB] = 1'b0;
    en_up = 4'b1111; tx_busy = '0; fifo_data = fd; ld_tx_data = 1;
    cyc(); fifo_data = fd2;
    cyc(); ld_tx_data = 0; chk("b2b_ld1", ld_uart, 4'b1111); chk("b2b_d1", tx_data[3*W +: W], fd);
    cyc(); chk("b2b_ld2", ld_uart, 4'b1111); chk("b2b_d2", tx_data[3*W +: W], fd2);
    chk("b2b_nodrop", tx_drop, 0);
    en_up = '0; en_dn = '0;
    repeat (2) cyc();
    // Port 1 second packet held off while its first is pending.
    comms_busy = 1; rx_empty = 4'b1110; rx_data_in[0 +: W] = 'h100;
    cyc(); rx_empty = '1; cyc(); cyc();
    rx_empty = 4'b1101; rx_data_in[W +: W] = 'h201;
    cyc(); chk("p1_first_uld", uld, 4'b0010);
    rx_data_in[W +: W] = 'h202;
    for (int k = 0; k < 5; k++) begin cyc(); chk("p1_held", uld[1], 0); end
    comms_busy = 0;
    for (int k = 0; k < 30; k++) begin
      cyc();
      if (rx_data_flag) q.push_back(rx_data);
      if (m_uld[1]) rx_empty[1] = 1'b1;
    end
    chk("p1_count", q.size(), 2);
    if (q.size() == 2) begin chk("p1_order0", q[0], 'h201); chk("p1_order1", q[1], 'h202); end
    // Reset during WAIT with ports 1 and 3 pending.
    comms_busy = 1; rx_empty = 4'b1110; rx_data_in[0 +: W] = 'h300;
    cyc(); rx_empty = '1; cyc(); cyc();
    rx_empty = 4'b0101;
    cyc(); chk("p13_uld", uld, 4'b1010);
    rx_empty = '1; cyc(); cyc();
    do_reset();
    comms_busy = 0; seen = 0;
    for (int k = 0; k < 8; k++) begin cyc(); seen += rx_data_flag; end
    chk("rst_discard", seen, 0);
    // Randomized traffic.
    busy_hold = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        rx_empty[i] = ($urandom_range(0, 3) != 0);
        rx_data_in[i*W +: W] = rnd();
      end
      en_posi = N'($urandom()); en_up = N'($urandom()); en_dn = N'($urandom());
      tx_busy = N'($urandom()) & N'($urandom());
      ld_tx_data = $urandom_range(0, 1); fifo_data = rnd();
      if (busy_hold == 0 && $urandom_range(0, 149) == 0) busy_hold = 60;
      if (busy_hold > 0) begin comms_busy = 1; busy_hold--; end
      else comms_busy = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 999) == 0) do_reset();
      cyc();
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
